// File: rtl/seg_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                                 |
// | Function : 4-digit seven-segment scan controller. It holds a double-     |
// |            buffered display value, with commits made at frame           |
// |            boundaries.                                                   |
// | Option   : LEADING_ZERO_BLANK_EN darks leading-zero digits (not slot 0). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic        frame_done
);

  localparam int              c_PW    = $clog2(CLK_DIV);
  localparam logic [c_PW-1:0] c_LAST  = c_PW'(CLK_DIV - 1);
  localparam logic [c_PW-1:0] c_BLANK = c_PW'(BLANK_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PW-1:0]   r_presc;
  logic [c_PW-1:0]   w_presc_nxt;
  logic [1:0]        r_slot;
  logic [1:0]        w_slot_nxt;
  logic [15:0]       r_active;
  logic [15:0]       w_active_nxt;
  logic [15:0]       r_pend;
  logic [15:0]       w_pend_nxt;
  logic              r_pend_full;
  logic              w_pend_full_nxt;
  logic              r_ready;
  logic [3:0]        r_anode;
  logic [3:0]        r_digit;
  logic              r_frame_done;
  logic              w_acc;
  logic              w_wrap;
  logic              w_commit;
  logic              w_dark;
  logic [3:0]        w_anode_nxt;
  logic [3:0]        w_digit_nxt;

  assign load_ready     = r_ready;
  assign refreshcounter = r_slot;
  assign anode          = r_anode;
  assign digit          = r_digit;
  assign frame_done     = r_frame_done;

  assign w_acc    = load_valid && !r_pend_full;
  assign w_wrap   = (r_state != S_IDLE) && enable && (r_slot == 2'd3) && (r_presc == c_LAST);
  // IDLE commits straight away so a dark display can still be updated.
  assign w_commit = r_pend_full && (w_wrap || (r_state == S_IDLE));

  // Scan sequencing: state, prescaler and slot.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_slot_nxt  = r_slot;
    unique case (r_state)
      S_IDLE: begin
        w_presc_nxt = '0;
        w_slot_nxt  = 2'd0;
        if (enable) begin
          w_state_nxt = (c_BLANK == '0) ? S_ON : S_BLANK;
        end
      end
      S_BLANK, S_ON: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
          w_slot_nxt  = 2'd0;
        end else begin
          if (r_presc == c_LAST) begin
            w_presc_nxt = '0;
            w_slot_nxt  = r_slot + 2'd1;
          end else begin
            w_presc_nxt = r_presc + c_PW'(1);
          end
          w_state_nxt = (w_presc_nxt < c_BLANK) ? S_BLANK : S_ON;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_presc_nxt = '0;
        w_slot_nxt  = 2'd0;
      end
    endcase
  end

  always_comb begin
    w_active_nxt    = r_active;
    w_pend_nxt      = r_pend;
    w_pend_full_nxt = r_pend_full;
    if (w_commit) begin
      w_active_nxt    = r_pend;
      w_pend_full_nxt = 1'b0;
    end
    if (w_acc) begin
      w_pend_nxt      = load_data;
      w_pend_full_nxt = 1'b1;
    end
  end

  // Outputs are derived from next-state values so they register in step.
  always_comb begin
    w_dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (w_slot_nxt)
      2'd1:    w_dark = (w_active_nxt[15:4]  == 12'd0);
      2'd2:    w_dark = (w_active_nxt[15:8]  == 8'd0);
      2'd3:    w_dark = (w_active_nxt[15:12] == 4'd0);
      default: w_dark = 1'b0;
    endcase
`else
    w_dark = 1'b0;
`endif
    w_anode_nxt = 4'hF;
    if ((w_state_nxt == S_ON) && !w_dark) begin
      w_anode_nxt = ~(4'b0001 << w_slot_nxt);
    end
    case (w_slot_nxt)
      2'd0:    w_digit_nxt = w_active_nxt[3:0];
      2'd1:    w_digit_nxt = w_active_nxt[7:4];
      2'd2:    w_digit_nxt = w_active_nxt[11:8];
      default: w_digit_nxt = w_active_nxt[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_slot       <= 2'd0;
      r_active     <= 16'h0000;
      r_pend       <= 16'h0000;
      r_pend_full  <= 1'b0;
      r_ready      <= 1'b1;
      r_anode      <= 4'hF;
      r_digit      <= 4'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_slot       <= w_slot_nxt;
      r_active     <= w_active_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_full  <= w_pend_full_nxt;
      r_ready      <= !w_pend_full_nxt;
      r_anode      <= w_anode_nxt;
      r_digit      <= w_digit_nxt;
      r_frame_done <= w_wrap;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_seg_scan_ctrl                                              |
// | Function : Self-checking bench for seg_scan_ctrl (CLK_DIV=8, BLANK=2).   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * CLK_DIV;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        load_ready;
  logic [1:0]  refreshcounter;
  logic [3:0]  anode;
  logic [3:0]  digit;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready),
    .refreshcounter(refreshcounter), .anode(anode), .digit(digit),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: scan position is a single phase count within the frame.
  bit          m_scan;
  int          m_phase;
  logic [15:0] m_active, m_pend;
  bit          m_full, m_fd;
  bit          m_acc, m_wrap, m_commit;
  int          e_slot, e_p;
  bit          e_lit;

  always @(posedge clk) begin
    if (reset) begin
      m_scan = 0; m_phase = 0; m_active = 16'h0; m_pend = 16'h0; m_full = 0; m_fd = 0;
    end else begin
      m_acc    = load_valid && !m_full;
      m_wrap   = m_scan && enable && (m_phase == FRAME - 1);
      m_commit = m_full && (m_wrap || !m_scan);
      if (m_commit) begin m_active = m_pend; m_full = 0; end
      if (m_acc) begin m_pend = load_data; m_full = 1; end
      if (!m_scan) begin
        if (enable) begin m_scan = 1; m_phase = 0; end
      end else if (!enable) begin
        m_scan = 0; m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % FRAME;
      end
      m_fd = m_wrap;
    end
    #1;
    e_slot = m_scan ? m_phase / CLK_DIV : 0;
    e_p    = m_phase % CLK_DIV;
    e_lit  = m_scan && (e_p >= BLANK_CYC) &&
             !(LZB && e_slot != 0 && ((m_active >> (4 * e_slot)) == 16'h0));
    chk("model_refreshcounter", 32'(refreshcounter), 32'(e_slot));
    chk("model_anode", 32'(anode), e_lit ? 32'(4'hF & ~(4'b0001 << e_slot)) : 32'hF);
    chk("model_digit", 32'(digit), 32'((m_active >> (4 * e_slot)) & 16'hF));
    chk("model_load_ready", 32'(load_ready), 32'(!m_full));
    chk("model_frame_done", 32'(frame_done), 32'(m_fd));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_rc", 32'(refreshcounter), 32'h0);
    chk("rst_digit", 32'(digit), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);

    // Plain scanning
    reset = 1'b0; enable = 1'b1;
    cyc(1);  chk("scan_p0_anode", 32'(anode), 32'hF);
    cyc(2);  chk("scan_p2_anode", 32'(anode), 32'hE);
    cyc(8);  chk("scan_p10_anode", 32'(anode), 32'hD);
             chk("scan_p10_rc", 32'(refreshcounter), 32'h1);
    cyc(21); chk("scan_p31_anode", 32'(anode), 32'h7);
             chk("scan_p31_fd", 32'(frame_done), 32'h0);
    cyc(1);  chk("scan_wrap_fd", 32'(frame_done), 32'h1);
             chk("scan_wrap_rc", 32'(refreshcounter), 32'h0);

    // Load mid-slot-1, commit at wrap
    cyc(10); load_valid = 1'b1; load_data = 16'h1234;
    cyc(1);  chk("load_ready_drop", 32'(load_ready), 32'h0);
             chk("load_old_digit", 32'(digit), 32'h0);
             load_valid = 1'b0;
    cyc(21); chk("commit_digit0", 32'(digit), 32'h4);
             chk("commit_ready", 32'(load_ready), 32'h1);
             chk("commit_fd", 32'(frame_done), 32'h1);
    cyc(8);  chk("commit_digit1", 32'(digit), 32'h3);

    // Second load while pending full
    load_valid = 1'b1; load_data = 16'hAAAA;
    cyc(1);  chk("full_ready", 32'(load_ready), 32'h0);
             load_data = 16'hBEEF;
    cyc(23); chk("second_commit_digit", 32'(digit), 32'hA);
             chk("second_wrap_ready", 32'(load_ready), 32'h1);
    cyc(1);  chk("second_accept", 32'(load_ready), 32'h0);
             load_valid = 1'b0;

    // Disable mid-slot-2, commit in IDLE, re-enable
    cyc(18); chk("slot2_rc", 32'(refreshcounter), 32'h2);
             enable = 1'b0;
    cyc(1);  chk("idle_anode", 32'(anode), 32'hF);
             chk("idle_rc", 32'(refreshcounter), 32'h0);
    cyc(1);  chk("idle_commit_ready", 32'(load_ready), 32'h1);
             chk("idle_commit_digit", 32'(digit), 32'hF);
             enable = 1'b1;
    cyc(1);  chk("reen_blank", 32'(anode), 32'hF);
    cyc(2);  chk("reen_on", 32'(anode), 32'hE);

    // Reset mid-ON with pending full
    load_valid = 1'b1; load_data = 16'h1234;
    cyc(1);  load_valid = 1'b0;
             chk("pre_reset_ready", 32'(load_ready), 32'h0);
    cyc(1);  reset = 1'b1; enable = 1'b0;
    cyc(1);  chk("mid_rst_anode", 32'(anode), 32'hF);
             chk("mid_rst_digit", 32'(digit), 32'h0);
             chk("mid_rst_ready", 32'(load_ready), 32'h1);
    cyc(1);

    // Leading-zero patterns
    reset = 1'b0; enable = 1'b1; load_valid = 1'b1; load_data = 16'h0050;
    cyc(1);  load_valid = 1'b0;
    cyc(34); chk("lz_s0_anode", 32'(anode), 32'hE);
    cyc(8);  chk("lz_s1_anode", 32'(anode), 32'hD);
             chk("lz_s1_digit", 32'(digit), 32'h5);
    cyc(8);  chk("lz_s2_anode", 32'(anode), LZB ? 32'hF : 32'hB);
    cyc(8);  chk("lz_s3_anode", 32'(anode), LZB ? 32'hF : 32'h7);
             load_valid = 1'b1; load_data = 16'h0000;
    cyc(1);  load_valid = 1'b0;
    cyc(7);  chk("zero_s0_anode", 32'(anode), 32'hE);
             chk("zero_s0_digit", 32'(digit), 32'h0);
    cyc(8);  chk("zero_s1_anode", 32'(anode), LZB ? 32'hF : 32'hD);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 399) == 0);
      enable     = ($urandom_range(0, 99) < 96);
      load_valid = ($urandom_range(0, 9) < 3);
      load_data  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_data = 16'($urandom_range(0, 255));
      cyc(1);
    end
    reset = 1'b0; enable = 1'b0; load_valid = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
